div_arbiter: RTL

Two-requester arbiter and sequencer for the shared iterative RV32IM divider. It accepts divide requests from the core execute stage (requester 0) and the encryption accelerator (requester 1) over valid/ready handshakes, and grants them round-robin. It drives the divider's `oper_a`/`oper_b`/`fuct3`/`enable_div` contract, captures `div_o`/`divided_by_zero` on `div_finish`, and returns a tagged response. A watchdog aborts a hung division.

---
 rtl/div_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter and sequencer for the shared iterative divider. It keeps one
// divide in flight, returns a tagged response, and aborts via watchdog if the divider hangs.
module div_arbiter #(
    parameter int length  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [length-1:0] req0_a,
    input  logic [length-1:0] req0_b,
    input  logic [length-1:0] req1_a,
    input  logic [length-1:0] req1_b,
    input  logic [1:0]        req_fuct3,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [length-1:0] rsp_result,
    output logic              rsp_div_by_zero,
    output logic              rsp_timeout,
    input  logic              rsp_ready,
    output logic [length-1:0] oper_a,
    output logic [length-1:0] oper_b,
    output logic              fuct3,
    output logic              enable_div,
    input  logic [length-1:0] div_o,
    input  logic              divided_by_zero,
    input  logic              div_finish
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_reg, state_next;
    logic              prio_reg;
    logic [CW-1:0]     cnt_reg;
    logic [length-1:0] oper_a_reg, oper_b_reg, result_reg;
    logic              fuct3_reg, id_reg, dbz_reg, tmo_reg;
    logic              grant, accept, finish_hit, timeout_hit, rsp_fire;

    // A lone valid requester wins outright; prio only breaks ties.
    assign grant = (&req_valid) ? prio_reg : req_valid[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && !rst && req_valid[gi]
                                   && (grant == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        finish_hit  = 1'b0;
        timeout_hit = 1'b0;
        rsp_fire    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_ready) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // A finish on the threshold cycle still counts as a real result.
                if (div_finish) begin
                    finish_hit = 1'b1;
                    state_next = RESP;
                end else if (cnt_reg == LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg   <= 1'b0;
            cnt_reg    <= '0;
            oper_a_reg <= '0;
            oper_b_reg <= '0;
            fuct3_reg  <= 1'b0;
            id_reg     <= 1'b0;
            result_reg <= '0;
            dbz_reg    <= 1'b0;
            tmo_reg    <= 1'b0;
        end else begin
            if (accept) begin
                oper_a_reg <= grant ? req1_a : req0_a;
                oper_b_reg <= grant ? req1_b : req0_b;
                fuct3_reg  <= req_fuct3[grant];
                id_reg     <= grant;
                cnt_reg    <= '0;
            end else if (state_reg == BUSY) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (finish_hit) begin
                result_reg <= div_o;
                dbz_reg    <= divided_by_zero;
                tmo_reg    <= 1'b0;
            end else if (timeout_hit) begin
                result_reg <= '0;
                dbz_reg    <= 1'b0;
                tmo_reg    <= 1'b1;
            end
            if (rsp_fire) begin
                prio_reg <= ~id_reg;
            end
        end
    end

    assign enable_div      = (state_reg == BUSY);
    assign rsp_valid       = (state_reg == RESP);
    assign oper_a          = oper_a_reg;
    assign oper_b          = oper_b_reg;
    assign fuct3           = fuct3_reg;
    assign rsp_id          = id_reg;
    assign rsp_result      = result_reg;
    assign rsp_div_by_zero = dbz_reg;
    assign rsp_timeout     = tmo_reg;

endmodule
